// File: rtl/alu_divider_if.sv
// Request/response bundle between execute control and the multi-cycle divider.
interface alu_divider_if #(
    parameter int N = 32
);
    logic         start;
    logic         is_signed;
    logic [N-1:0] dividend;
    logic [N-1:0] divisor;
    logic         busy;
    logic         done;
    logic [N-1:0] quotient;
    logic [N-1:0] remainder;
    logic         div_by_zero;

    modport master (
        output start, is_signed, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, is_signed, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/alu_divider.sv
// Restoring integer divider: one quotient bit per clock on operand magnitudes,
// signs re-applied in a final fix-up cycle (truncating division).
module alu_divider #(
    parameter int N = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    alu_divider_if.slave      bus
);
    localparam int            CW        = $clog2(N + 1);
    localparam logic [CW-1:0] LAST_STEP = CW'(N - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2
    } state_t;

    function automatic logic [N-1:0] neg2c(input logic [N-1:0] v);
        return ~v + {{(N-1){1'b0}}, 1'b1};
    endfunction

    state_t        r_state;
    logic [CW-1:0] r_count;
    // Partial remainder is always below the divisor magnitude, so its top bit
    // of the (N+1)-bit working value is implicitly zero and not stored.
    logic [N-1:0]  r_prem;
    logic [N-1:0]  r_dvd_mag;
    logic [N-1:0]  r_dvs_mag;
    logic [N-1:0]  r_raw_dvd;
    logic          r_q_neg;
    logic          r_r_neg;
    logic          r_busy;
    logic          r_done;
    logic [N-1:0]  r_quotient;
    logic [N-1:0]  r_remainder;
    logic          r_dbz;

    logic [N-1:0]  w_dvd_mag;
    logic [N-1:0]  w_dvs_mag;
    logic          w_q_neg;
    logic          w_r_neg;
    logic [N:0]    w_shift;
    logic [N:0]    w_trial;

    // Operand magnitudes and result signs formed from the live request inputs
    always_comb begin
        w_dvd_mag = bus.dividend;
        w_dvs_mag = bus.divisor;
        w_q_neg   = 1'b0;
        w_r_neg   = 1'b0;
        if (bus.is_signed) begin
            if (bus.dividend[N-1]) begin
                w_dvd_mag = neg2c(bus.dividend);
            end else begin
                w_dvd_mag = bus.dividend;
            end
            if (bus.divisor[N-1]) begin
                w_dvs_mag = neg2c(bus.divisor);
            end else begin
                w_dvs_mag = bus.divisor;
            end
            w_q_neg = bus.dividend[N-1] ^ bus.divisor[N-1];
            w_r_neg = bus.dividend[N-1];
        end else begin
            w_q_neg = 1'b0;
            w_r_neg = 1'b0;
        end
    end

    // One restoring step: shift remainder/dividend pair and trial-subtract
    always_comb begin
        w_shift = {r_prem, r_dvd_mag[N-1]};
        w_trial = w_shift - {1'b0, r_dvs_mag};
    end

    // Divider control FSM with registered results and handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_count     <= {CW{1'b0}};
            r_prem      <= {N{1'b0}};
            r_dvd_mag   <= {N{1'b0}};
            r_dvs_mag   <= {N{1'b0}};
            r_raw_dvd   <= {N{1'b0}};
            r_q_neg     <= 1'b0;
            r_r_neg     <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_quotient  <= {N{1'b0}};
            r_remainder <= {N{1'b0}};
            r_dbz       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_raw_dvd <= bus.dividend;
                        r_dvd_mag <= w_dvd_mag;
                        r_dvs_mag <= w_dvs_mag;
                        r_q_neg   <= w_q_neg;
                        r_r_neg   <= w_r_neg;
                        r_prem    <= {N{1'b0}};
                        r_count   <= {CW{1'b0}};
                        r_busy    <= 1'b1;
                        r_state   <= ST_RUN;
                    end else begin
                        r_state   <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    // A negative trial leaves w_shift below 2^N, so restoring drops nothing
                    if (!w_trial[N]) begin
                        r_prem    <= w_trial[N-1:0];
                        r_dvd_mag <= {r_dvd_mag[N-2:0], 1'b1};
                    end else begin
                        r_prem    <= w_shift[N-1:0];
                        r_dvd_mag <= {r_dvd_mag[N-2:0], 1'b0};
                    end
                    r_count <= r_count + {{(CW-1){1'b0}}, 1'b1};
                    if (r_count == LAST_STEP) begin
                        r_state <= ST_FIX;
                    end else begin
                        r_state <= ST_RUN;
                    end
                end
                ST_FIX: begin
                    if (r_dvs_mag == {N{1'b0}}) begin
                        r_quotient  <= {N{1'b1}};
                        r_remainder <= r_raw_dvd;
                        r_dbz       <= 1'b1;
                    end else begin
                        r_quotient  <= r_q_neg ? neg2c(r_dvd_mag) : r_dvd_mag;
                        r_remainder <= r_r_neg ? neg2c(r_prem) : r_prem;
                        r_dbz       <= 1'b0;
                    end
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.quotient    = r_quotient;
    assign bus.remainder   = r_remainder;
    assign bus.div_by_zero = r_dbz;
endmodule
